// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared definitions for the sr_cmd_conditioner slice.
//   - sr_state_e         : conditioner FSM state encoding
//   - SR_SYNC_STAGES_DEF : default synchroniser depth
//   - SR_DB_CYCLES_DEF   : default debounce stability window, in clock cycles
//   - SR_CONFLICT_CNT_W  : width of the optional conflict counter
package sr_cmd_pkg;

    localparam int unsigned SR_SYNC_STAGES_DEF = 2;
    localparam int unsigned SR_DB_CYCLES_DEF   = 16;
    localparam int unsigned SR_CONFLICT_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SET_P   = 2'd1,
        RST_P   = 2'd2,
        LOCKOUT = 2'd3
    } sr_state_e;

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: one request channel of the command conditioner.
// Synchronises a raw asynchronous line, debounces it and emits a one-cycle
// event on each debounced rising edge.
//
// Parameters:
//   SYNC_STAGES : synchroniser flops (minimum 2)
//   DB_CYCLES   : consecutive differing synchronised cycles needed to flip (minimum 2)
//   CNT_W       : counter width, derived from DB_CYCLES
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   raw_i   : raw request line, asynchronous to clk
//   level_o : debounced level
//   rise_o  : one-cycle pulse after the debounced level goes 0->1
module sr_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned CNT_W       = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q;

    // Plain flop chain; nothing may look at the raw line before the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Counter tracks how long the synchronised level has disagreed with the
    // debounced level; any agreement restarts the window.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_lvl != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= db_d & ~db_q;
        end
    end

    assign level_o = db_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: front-end that turns raw set/reset request lines into
// clean single-cycle S/R pulses for sr_flip_flop, never driving S and R together.
//
// Optional feature: define SR_CMD_CONFLICT_CNT_EN to add conflict_cnt_o, a
// saturating count of conflict_o pulses.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth per channel (minimum 2)
//   DB_CYCLES   : debounce stability window in cycles (minimum 2)
// Ports:
//   clk            : clock
//   rst_n          : asynchronous active-low reset
//   set_req_i      : raw set request (asynchronous)
//   rst_req_i      : raw reset request (asynchronous)
//   s_o            : one-cycle S command
//   r_o            : one-cycle R command
//   conflict_o     : one-cycle pulse on a forbidden set/reset overlap
//   busy_o         : high while locked out after a conflict
//   conflict_cnt_o : saturating conflict count (SR_CMD_CONFLICT_CNT_EN only)
module sr_cmd_conditioner
    import sr_cmd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SR_SYNC_STAGES_DEF,
    parameter int unsigned DB_CYCLES   = SR_DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req_i,
    input  logic rst_req_i,
    output logic s_o,
    output logic r_o,
    output logic conflict_o,
    output logic busy_o
`ifdef SR_CMD_CONFLICT_CNT_EN
    ,
    output logic [SR_CONFLICT_CNT_W-1:0] conflict_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);

    logic set_lvl, set_ev;
    logic rst_lvl, rst_ev;

    sr_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .CNT_W       (CNT_W)
    ) u_set_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (set_req_i),
        .level_o (set_lvl),
        .rise_o  (set_ev)
    );

    sr_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .CNT_W       (CNT_W)
    ) u_rst_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (rst_req_i),
        .level_o (rst_lvl),
        .rise_o  (rst_ev)
    );

    sr_state_e state_q, state_d;
    logic      set_pend_q, set_pend_d;
    logic      rst_pend_q, rst_pend_d;
    logic      set_go, rst_go;
    logic      conflict_d;
    logic      s_q, r_q, conflict_q, busy_q;

    always_comb begin
        state_d    = state_q;
        set_pend_d = set_pend_q;
        rst_pend_d = rst_pend_q;
        conflict_d = 1'b0;
        set_go     = 1'b0;
        rst_go     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // An event held over from a pulse cycle only counts if its
                // line is still debounced high.
                set_go     = set_ev | (set_pend_q & set_lvl);
                rst_go     = rst_ev | (rst_pend_q & rst_lvl);
                set_pend_d = 1'b0;
                rst_pend_d = 1'b0;
                if ((set_go & rst_go) | (set_go & rst_lvl) | (rst_go & set_lvl)) begin
                    state_d    = LOCKOUT;
                    conflict_d = 1'b1;
                end else if (set_go) begin
                    state_d = SET_P;
                end else if (rst_go) begin
                    state_d = RST_P;
                end
            end
            SET_P, RST_P: begin
                set_pend_d = set_pend_q | set_ev;
                rst_pend_d = rst_pend_q | rst_ev;
                state_d    = IDLE;
            end
            LOCKOUT: begin
                set_pend_d = 1'b0;
                rst_pend_d = 1'b0;
                if (!set_lvl && !rst_lvl) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            set_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_pend_q <= set_pend_d;
            rst_pend_q <= rst_pend_d;
            s_q        <= (state_d == SET_P);
            r_q        <= (state_d == RST_P);
            conflict_q <= conflict_d;
            busy_q     <= (state_d == LOCKOUT);
        end
    end

    assign s_o        = s_q;
    assign r_o        = r_q;
    assign conflict_o = conflict_q;
    assign busy_o     = busy_q;

`ifdef SR_CMD_CONFLICT_CNT_EN
    logic [SR_CONFLICT_CNT_W-1:0] ccnt_q;

    // Counts in step with the conflict_o pulse it records; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccnt_q <= '0;
        end else if (conflict_d && (ccnt_q != '1)) begin
            ccnt_q <= ccnt_q + 1'b1;
        end
    end

    assign conflict_cnt_o = ccnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Self-checking bench for sr_cmd_conditioner (SYNC_STAGES=2, DB_CYCLES=4).
// Directed scenarios plus randomized traffic, all compared each cycle against
// a history-based reference model.
module tb_sr_cmd_conditioner;

    localparam int S  = 2;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic rst_req = 1'b0;
    logic s_o, r_o, conflict_o, busy_o;
`ifdef SR_CMD_CONFLICT_CNT_EN
    logic [7:0] cnt_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_cmd_conditioner #(
        .SYNC_STAGES (S),
        .DB_CYCLES   (DB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_req_i      (set_req),
        .rst_req_i      (rst_req),
        .s_o            (s_o),
        .r_o            (r_o),
        .conflict_o     (conflict_o),
        .busy_o         (busy_o)
`ifdef SR_CMD_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o (cnt_o)
`endif
    );

    // Reference model: raw samples since reset, debounced levels derived from
    // the sample history, and a command mode (0 idle, 1 S pulse, 2 R pulse, 3 lockout).
    bit hs[$];
    bit hr[$];
    int m_sdb, m_rdb, m_sev, m_rev, m_sp, m_rp, m_mode;
    int e_s, e_r, e_c, e_b, e_cnt;

    function automatic int samp(input int ch, input int idx);
        if (idx < 0) return 0;
        return (ch == 0) ? int'(hs[idx]) : int'(hr[idx]);
    endfunction

    // Level flips once the last DB synchronised samples all disagree with it.
    function automatic int flips(input int ch, input int db);
        int last;
        last = ((ch == 0) ? hs.size() : hr.size()) - 1;
        for (int j = 0; j < DB; j++) begin
            if (samp(ch, last - S - j) == db) return 0;
        end
        return 1;
    endfunction

    task automatic model_reset();
        hs.delete();
        hr.delete();
        m_sdb = 0; m_rdb = 0; m_sev = 0; m_rev = 0; m_sp = 0; m_rp = 0; m_mode = 0;
        e_s = 0; e_r = 0; e_c = 0; e_b = 0; e_cnt = 0;
    endtask

    task automatic model_edge();
        int se, re, nmode, nsdb, nrdb;
        hs.push_back(set_req);
        hr.push_back(rst_req);
        e_c   = 0;
        nmode = m_mode;
        if (m_mode == 0) begin
            se = (m_sev != 0 || (m_sp != 0 && m_sdb != 0)) ? 1 : 0;
            re = (m_rev != 0 || (m_rp != 0 && m_rdb != 0)) ? 1 : 0;
            m_sp = 0;
            m_rp = 0;
            if ((se != 0 && re != 0) || (se != 0 && m_rdb != 0) || (re != 0 && m_sdb != 0)) begin
                nmode = 3;
                e_c   = 1;
            end else if (se != 0) begin
                nmode = 1;
            end else if (re != 0) begin
                nmode = 2;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_sev != 0) m_sp = 1;
            if (m_rev != 0) m_rp = 1;
            nmode = 0;
        end else begin
            m_sp = 0;
            m_rp = 0;
            if (m_sdb == 0 && m_rdb == 0) nmode = 0;
        end
        nsdb  = (flips(0, m_sdb) != 0) ? 1 - m_sdb : m_sdb;
        nrdb  = (flips(1, m_rdb) != 0) ? 1 - m_rdb : m_rdb;
        m_sev = (nsdb == 1 && m_sdb == 0) ? 1 : 0;
        m_rev = (nrdb == 1 && m_rdb == 0) ? 1 : 0;
        m_sdb = nsdb;
        m_rdb = nrdb;
        m_mode = nmode;
        e_s = (m_mode == 1) ? 1 : 0;
        e_r = (m_mode == 2) ? 1 : 0;
        e_b = (m_mode == 3) ? 1 : 0;
        if (e_c != 0 && e_cnt < 255) e_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("s_o", 32'(s_o), e_s);
        check("r_o", 32'(r_o), e_r);
        check("conflict_o", 32'(conflict_o), e_c);
        check("busy_o", 32'(busy_o), e_b);
        check("s_r_exclusive", 32'(s_o & r_o), 0);
`ifdef SR_CMD_CONFLICT_CNT_EN
        check("conflict_cnt_o", 32'(cnt_o), e_cnt);
`endif
    endtask

    // One clock: model advances on the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses, at, hold;

        // Reset state.
        model_reset();
        #1;
        check_outputs();
        do_reset(3);
        repeat (3) step();

        // Clean set request: S pulse after edge 7 counting the first sampling edge as 1.
        set_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("set_latency", 32'(s_o), (i == 7) ? 1 : 0);
        end
        set_req = 1'b0;
        repeat (10) step();

        // Bouncing set request, stable from edge 5 onward.
        do_reset(2);
        pulses = 0;
        at = 0;
        for (int i = 1; i <= 25; i++) begin
            set_req = (i == 2 || i == 4) ? 1'b0 : 1'b1;
            step();
            if (s_o) begin
                pulses++;
                at = i;
            end
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_latency", at, 11);
        set_req = 1'b0;
        repeat (10) step();

        // Simultaneous rise: one conflict, lockout, exits 7 edges after the drop.
        do_reset(2);
        pulses = 0;
        set_req = 1'b1;
        rst_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (conflict_o) pulses++;
        end
        check("both_conflict_pulses", pulses, 1);
        check("both_busy", 32'(busy_o), 1);
        set_req = 1'b0;
        rst_req = 1'b0;
        at = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (!busy_o && at == 0) at = i;
        end
        check("busy_release", at, 7);

        // Set held high, then reset rises: conflict and lockout.
        do_reset(2);
        set_req = 1'b1;
        repeat (12) step();
        pulses = 0;
        rst_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (conflict_o) pulses++;
        end
        check("late_conflict_pulses", pulses, 1);
        check("late_busy", 32'(busy_o), 1);
`ifdef SR_CMD_CONFLICT_CNT_EN
        check("late_conflict_cnt", 32'(cnt_o), 1);
`endif
        set_req = 1'b0;
        rst_req = 1'b0;
        repeat (12) step();

        // Reset in the middle of debouncing a held reset request.
        do_reset(2);
        rst_req = 1'b1;
        repeat (3) step();
        do_reset(3);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("reset_restart_r", 32'(r_o), (i == 7) ? 1 : 0);
        end
        rst_req = 1'b0;
        repeat (10) step();

`ifdef SR_CMD_CONFLICT_CNT_EN
        // 300 forced conflicts: counter saturates.
        do_reset(2);
        for (int k = 0; k < 300; k++) begin
            set_req = 1'b1;
            rst_req = 1'b1;
            repeat (9) step();
            set_req = 1'b0;
            rst_req = 1'b0;
            repeat (9) step();
        end
        check("cnt_saturate", 32'(cnt_o), 255);
`endif

        // Randomized traffic with glitches and occasional resets.
        do_reset(2);
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) do_reset(2);
            set_req = 1'($urandom_range(0, 1));
            rst_req = 1'($urandom_range(0, 3) == 0);
            hold = $urandom_range(1, 12);
            repeat (hold) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_cmd_conditioner.md
Name: sr_cmd_conditioner

Overview:
- Upstream front-end for the team's sr_flip_flop. It drives the flip-flop's S and R inputs.
- Takes two raw, asynchronous, possibly bouncing request lines: set and reset.
- Synchronises and debounces each line, then converts its debounced rising edge into a single-cycle S or R pulse.
- Never lets the S=R=1 forbidden combination reach the flip-flop; flags it as a conflict instead.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchroniser chain (minimum 2).
- DB_CYCLES, 16, consecutive stable synchronised cycles required before the debounced level changes (minimum 2).
- CNT_W, $clog2(DB_CYCLES), width of each debounce counter; derived, not overridden.

Ports:
- clk  input  1  single clock for the block.
- rst_n  input  1  asynchronous, active-low reset.
- set_req_i  input  1  raw set request; asynchronous to clk.
- rst_req_i  input  1  raw reset request; asynchronous to clk.
- s_o  output  1  S command to sr_flip_flop; one-cycle pulse.
- r_o  output  1  R command to sr_flip_flop; one-cycle pulse.
- conflict_o  output  1  one-cycle pulse when a forbidden set/reset overlap is detected.
- busy_o  output  1  high while in LOCKOUT.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchroniser flops, debounced levels, counters and outputs go to 0.
  - FSM goes to IDLE. Asserting reset mid-pulse truncates the pulse immediately.
  - A raw input still high after reset release is treated as a fresh rising edge and produces a pulse after the full latency.
- Synchronisation: each input passes through a SYNC_STAGES flop chain. No logic is applied before the last stage.
- Debounce, per channel:
  - Counter clears to 0 on any cycle where the synchronised level equals the debounced level.
  - Counter otherwise increments. When it reaches DB_CYCLES-1 and the levels still differ, the debounced level flips on the next edge and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes the debounced level.
- Edge detect: a debounced 0->1 transition on a channel is an "event" for one cycle. Falling edges generate nothing.
- FSM states: IDLE, SET_P, RST_P, LOCKOUT.
  - IDLE, set event only, reset channel debounced low -> SET_P.
  - IDLE, reset event only, set channel debounced low -> RST_P.
  - IDLE, both events in the same cycle, or an event while the other channel is debounced high -> LOCKOUT; conflict_o=1 for that cycle; no pulse is issued.
  - SET_P: s_o=1 for exactly one cycle -> IDLE.
  - RST_P: r_o=1 for exactly one cycle -> IDLE.
  - LOCKOUT: busy_o=1; stay until both debounced levels are 0, then -> IDLE. Events during LOCKOUT are discarded.
- Outputs are registered, and s_o & r_o is never 1.
- Latency: a clean raw 0->1 edge first sampled at clock edge k gives s_o/r_o high in the cycle after edge k+SYNC_STAGES+DB_CYCLES.
- Back-to-back: an event arriving while in SET_P/RST_P is honoured after return to IDLE only if its debounced level is still high. Otherwise it is dropped.

Optional Feature:
- Macro: SR_CMD_CONFLICT_CNT_EN.
- Defined:
  - Adds output conflict_cnt_o [7:0]: increments on every conflict_o pulse and saturates at 8'hFF.
  - Reset clears it to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package sr_cmd_pkg holds:
  - the FSM state enum (IDLE, SET_P, RST_P, LOCKOUT);
  - default constants SR_SYNC_STAGES_DEF=2 and SR_DB_CYCLES_DEF=16;
  - the conflict counter width constant (8).
- Sub-module sr_debounce handles one channel: synchroniser, debounce counter, debounced level and rise-event output. It is instantiated twice. The top level contains only the FSM, output registers and the optional counter.

Test Plan (SYNC_STAGES=2, DB_CYCLES=4):
- set_req_i 0->1, held 20 cycles -> s_o high exactly one cycle, 7 cycles after the first sampling edge; r_o, conflict_o stay 0.
- set_req_i bounce 1,0,1,0 (1 cycle each), then stable 1 -> exactly one s_o pulse, timed from the start of the stable level.
- set_req_i and rst_req_i rise on the same edge, held -> conflict_o one pulse, busy_o=1, no s_o/r_o. Drop both -> busy_o clears 4+2+1 cycles later.
- set_req_i held high, then rst_req_i rises -> conflict_o pulse and LOCKOUT; with SR_CMD_CONFLICT_CNT_EN, conflict_cnt_o = 1.
- rst_n asserted for 3 cycles mid-debounce of rst_req_i, with the input held high -> all outputs 0 during reset; one r_o pulse 7 cycles after release.
- 300 forced conflicts with SR_CMD_CONFLICT_CNT_EN -> conflict_cnt_o saturates at 255.
